// File: rtl/counter_arbiter_if.sv
// counter_arbiter_if
//   Request/grant bundle between the requesters (master side) and the shared
//   counter scheduler (slave side).
//   Parameters: NREQ  - number of requesters
//               WIDTH - counter and run-length width
//   Signals:    req     requester level requests          (master -> slave)
//               len     packed run lengths, WIDTH each    (master -> slave)
//               grant   one-hot counter ownership         (slave -> master)
//               busy    job in RUN or DONE                (slave -> master)
//               value   current counter value             (slave -> master)
//               done    one-cycle completion pulse        (slave -> master)
//               done_id id of the completed job           (slave -> master)
interface counter_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [WIDTH-1:0]      value;
    logic                  done;
    logic [IDW-1:0]        done_id;

    modport master (
        output req, len,
        input  grant, busy, value, done, done_id
    );

    modport slave (
        input  req, len,
        output grant, busy, value, done, done_id
    );
endinterface

// File: rtl/counter_arbiter.sv
// counter_arbiter
//   Round-robin scheduler sharing one WIDTH-bit up-counter among NREQ
//   requesters. The winner's length is latched at grant, the counter runs
//   0..len-1, then done pulses for one cycle tagged with the winner's id.
//   A zero-length request skips RUN and goes straight to DONE without grant.
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous, active-low; clears all state
//     bus   - counter_arbiter_if.slave (req, len, grant, busy, value,
//             done, done_id)
//   Build option:
//     COUNTER_ARB_ABORT_EN - when defined, dropping the owner's req during
//                            RUN abandons the job (back to IDLE, value 0,
//                            no done pulse).
module counter_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    counter_arbiter_if.slave   bus
);
    localparam int          IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR  = NREQ;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [IDW-1:0]   last, last_n;
    logic [WIDTH-1:0] len_q, len_n;
    logic [WIDTH-1:0] value_q, value_n;
    logic [NREQ-1:0]  grant_q, grant_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic [IDW-1:0]   done_id_q, done_id_n;

    logic [IDW-1:0]   win;
    logic [NREQ-1:0]  win_oh;
    logic [WIDTH-1:0] win_len;
    logic             abort;

    // Walk offsets from NREQ down to 1 so the smallest offset from last
    // (i.e. the first requester after last) is the one left in win.
    always_comb begin
        win = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            int unsigned    p;
            logic [IDW-1:0] cand;
            p = 32'(last) + NR - i;
            if (p >= NR) p = p - NR;
            cand = IDW'(p);
            if (bus.req[cand]) win = cand;
        end
    end

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
        win_len     = bus.len[32'(win) * WIDTH +: WIDTH];
    end

`ifdef COUNTER_ARB_ABORT_EN
    assign abort = !bus.req[last];
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= IDW'(NREQ - 1);
            len_q     <= '0;
            value_q   <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            len_q     <= len_n;
            value_q   <= value_n;
            grant_q   <= grant_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            done_id_q <= done_id_n;
        end
    end

    always_comb begin
        state_n   = state;
        last_n    = last;
        len_n     = len_q;
        value_n   = value_q;
        grant_n   = grant_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        done_id_n = done_id_q;

        unique case (state)
            IDLE: begin
                if (|bus.req) begin
                    last_n = win;
                    if (win_len != '0) begin
                        len_n   = win_len;
                        grant_n = win_oh;
                        value_n = '0;
                        busy_n  = 1'b1;
                        state_n = RUN;
                    end else begin
                        grant_n   = '0;
                        busy_n    = 1'b1;
                        done_n    = 1'b1;
                        done_id_n = win;
                        state_n   = DONE;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    grant_n = '0;
                    busy_n  = 1'b0;
                    value_n = '0;
                    state_n = IDLE;
                end else if (value_q == len_q - WIDTH'(1)) begin
                    grant_n   = '0;
                    done_n    = 1'b1;
                    done_id_n = last;
                    state_n   = DONE;
                end else begin
                    value_n = value_q + WIDTH'(1);
                end
            end
            DONE: begin
                grant_n = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                grant_n = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.value   = value_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
endmodule

// File: tb/tb_counter_arbiter.sv
module tb_counter_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk;
    logic reset;

    counter_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboard of done_id values the bench expects, in completion order.
    logic [1:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every done pulse must match the oldest expected completion; a pulse
    // with nothing expected is itself a failure.
    always @(negedge clk) begin
        if (reset && bus.done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 done_id=%0d, required no done", bus.done_id);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (bus.done_id !== e) begin
                    errors++;
                    $display("FAIL done_id: got %0d, required %0d", bus.done_id, e);
                end
            end
        end
    end

    task automatic set_len(input int i, input logic [WIDTH-1:0] v);
        bus.len[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        bus.req = '0;
        bus.len = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.value !== 8'd0 ||
            bus.done !== 1'b0 || bus.done_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b busy=%b value=%0d done=%b done_id=%0d, required all 0",
                     bus.grant, bus.busy, bus.value, bus.done, bus.done_id);
        end
    endtask

    task automatic test_single();
        int n;
        set_len(0, 8'd5);
        bus.req = 4'b0001;
        exp_q.push_back(2'd0);
        n = 0;
        while (bus.grant === 4'b0000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.grant !== 4'b0001 || bus.value !== 8'(i) || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL single_run[%0d]: got grant=%b value=%0d busy=%b, required grant=0001 value=%0d busy=1",
                         i, bus.grant, bus.value, bus.busy, i);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.grant !== 4'b0000 || bus.value !== 8'd4) begin
            errors++;
            $display("FAIL single_done: got done=%b grant=%b value=%0d, required done=1 grant=0000 value=4",
                     bus.done, bus.grant, bus.value);
        end
        bus.req = '0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after: got done=%b busy=%b, required done=0 busy=0", bus.done, bus.busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int n;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_g;
        // Fresh reset so requester 0 has first priority again.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_len(i, 8'd2);
        bus.req = 4'b1111;
        for (int j = 0; j < 5; j++) exp_q.push_back(2'(order[j]));
        for (int j = 0; j < 5; j++) begin
            exp_g = 4'b0001 << order[j];
            n = 0;
            while (bus.grant === 4'b0000 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (bus.grant !== exp_g || bus.value !== 8'd0) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got grant=%b value=%0d, required grant=%b value=0",
                         j, bus.grant, bus.value, exp_g);
            end
            @(negedge clk);
            checks++;
            if (bus.grant !== exp_g || bus.value !== 8'd1) begin
                errors++;
                $display("FAIL rr_hold[%0d]: got grant=%b value=%0d, required grant=%b value=1",
                         j, bus.grant, bus.value, exp_g);
            end
            @(negedge clk);
            checks++;
            if (bus.grant !== 4'b0000 || bus.done !== 1'b1) begin
                errors++;
                $display("FAIL rr_done[%0d]: got grant=%b done=%b, required grant=0000 done=1",
                         j, bus.grant, bus.done);
            end
            if (j == 4) bus.req = '0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_zero_len();
        set_len(2, 8'd0);
        bus.req = 4'b0100;
        exp_q.push_back(2'd2);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.grant !== 4'b0000 || bus.done_id !== 2'd2) begin
            errors++;
            $display("FAIL zero_len: got done=%b grant=%b done_id=%0d, required done=1 grant=0000 done_id=2",
                     bus.done, bus.grant, bus.done_id);
        end
        bus.req = '0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
            errors++;
            $display("FAIL zero_len_after: got done=%b busy=%b grant=%b, required 0 0 0000",
                     bus.done, bus.busy, bus.grant);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int n;
        set_len(0, 8'd8);
        bus.req = 4'b0001;
        n = 0;
        while (!(bus.grant === 4'b0001 && bus.value === 8'd3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.value !== 8'd3) begin
            errors++;
            $display("FAIL mid_run_reach: got value=%0d, required 3", bus.value);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.value !== 8'd0 ||
            bus.done !== 1'b0 || bus.done_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_run_reset: got grant=%b busy=%b value=%0d done=%b done_id=%0d, required all 0",
                     bus.grant, bus.busy, bus.value, bus.done, bus.done_id);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(2'd0);
        n = 0;
        while (bus.grant === 4'b0000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.grant !== 4'b0001 || bus.value !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_grant: got grant=%b value=%0d, required grant=0001 value=0",
                     bus.grant, bus.value);
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.done !== 1'b1 || bus.value !== 8'd7) begin
            errors++;
            $display("FAIL post_reset_done: got done=%b value=%0d, required done=1 value=7", bus.done, bus.value);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        int n;
        set_len(0, 8'd10);
        bus.req = 4'b0001;
        n = 0;
        while (!(bus.grant === 4'b0001 && bus.value === 8'd2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.value !== 8'd2) begin
            errors++;
            $display("FAIL abort_reach: got value=%0d, required 2", bus.value);
        end
        bus.req = '0;
`ifdef COUNTER_ARB_ABORT_EN
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.value !== 8'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got grant=%b busy=%b value=%0d done=%b, required 0000 0 0 0",
                     bus.grant, bus.busy, bus.value, bus.done);
        end
        repeat (12) @(negedge clk);
`else
        exp_q.push_back(2'd0);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.done !== 1'b1 || bus.value !== 8'd9) begin
            errors++;
            $display("FAIL no_abort_done: got done=%b value=%0d, required done=1 value=9", bus.done, bus.value);
        end
        repeat (3) @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_reset_mid_run();
        test_abort();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending completions, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin scheduler that shares one WIDTH-bit up-counter between NREQ requesters. Each requester asks for a timed run of a given length. The block grants one requester at a time, latches its length, runs the counter from 0 to len-1, and pulses done tagged with the winner's id. It sits between the vcpu control logic and the shared counter, which is owned exclusively by this block.

## Interface
Parameters:
- NREQ, default 4: number of requesters (2..8).
- WIDTH, default 8: counter and length width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- req  in  NREQ  per-requester level request; held high until the job completes.
- len  in  NREQ*WIDTH  requester i's run length on len[i*WIDTH +: WIDTH]; sampled only at grant.
- grant  out  NREQ  one-hot; bit i is high while requester i owns the counter.
- busy  out  1  high in RUN and DONE.
- value  out  WIDTH  current counter value.
- done  out  1  one-cycle pulse when a job completes.
- done_id  out  $clog2(NREQ)  id of the completed job; valid while done=1, otherwise holds its last value.

## Operation
- States: IDLE, RUN, DONE.
- Round-robin pointer `last` holds the id of the most recent winner. Search starts at last+1 mod NREQ. The first set req bit wins.
- IDLE:
  - If no req, stay in IDLE.
  - If the winner has len != 0: latch len, set grant[w]=1, set value=0, go to RUN.
  - If the winner has len == 0: grant is never asserted; go directly to DONE with done_id=w.
  - In both cases, set last=w.
- RUN:
  - value increments by 1 each cycle.
  - When value == latched_len-1, go to DONE. value holds at len-1.
  - No wrap-around is possible, because the maximum len is 2^WIDTH-1.
- DONE:
  - grant=0, done=1, done_id=last.
  - value holds its final value.
  - Next state is IDLE unconditionally, so there is always one IDLE cycle between jobs.
- req changes during RUN or DONE do not affect the current job (see Configuration for the exception). They are seen at the next IDLE evaluation.
- A requester that keeps req high after done is re-arbitrated normally. With other requesters pending, round-robin moves past it.
- Reset mid-operation: on reset=0, the current job is discarded, with no done and no pulse.
- Reset values: state=IDLE, grant=0, busy=0, done=0, done_id=0, value=0, last=NREQ-1 (so requester 0 has first priority).

## Timing
- Edge k in IDLE samples req. From edge k+1: grant=one-hot, value=0, busy=1.
- value equals len-1 after edge k+len. DONE begins at edge k+len+1, with done=1 for exactly one cycle. IDLE resumes at edge k+len+2.
- A job with len=L occupies L+2 cycles, counted from the sampling edge to return to IDLE. Back-to-back grants are spaced L+2 cycles apart.
- len=0: done pulses at edge k+1 and IDLE resumes at edge k+2; grant stays 0 throughout.
- Outputs are registered. There is no combinational path from req or len to any output.

## Configuration
- COUNTER_ARB_ABORT_EN
  - Defined: if the granted requester's req is 0 during RUN, the next edge goes to IDLE with grant=0, busy=0 and value=0. done is not pulsed, and last still advances to that requester.
  - Undefined: req is ignored after grant, and every granted job runs to completion and pulses done.

## Test plan
- Reset is low for 3 cycles then released, with req=0 -> all outputs 0; the block stays in IDLE.
- req=4'b0001, len0=5 -> grant=0001 for 5 cycles with value 0,1,2,3,4; then done=1 and done_id=0 for one cycle; busy=0 afterwards.
- req=4'b1111 held, all len=2 -> grants go 0,1,2,3,0 in that order, each spaced 4 cycles apart, and done_id follows the same sequence.
- req=4'b0100, len2=0 -> grant stays 0; done=1 and done_id=2 one cycle after sampling.
- reset pulled low during RUN with value=3 -> all outputs 0 immediately and no done pulse; after release, a pending req is granted normally.
- With COUNTER_ARB_ABORT_EN defined, req0 is dropped at value=2 of len=10 -> the block is in IDLE next cycle and done never pulses. Without the macro, the job runs to value=9 and done pulses.
